// File: rtl/fc_vec_packer.sv
// Serial-to-parallel packer for fully-connected layer inputs.
// Collects FC_IN_VEC elements, one per valid cycle, into a staging buffer.
// A completed vector is copied into a separate output register one cycle
// after its last element, so the next vector can begin filling at once.
`ifndef FC_IN_VEC
`define FC_IN_VEC 48
`endif
`ifndef OF_BW
`define OF_BW 32
`endif

module fc_vec_packer #(
  parameter int FC_IN_VEC = `FC_IN_VEC,
  parameter int OF_BW     = `OF_BW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_in_valid,
  input  logic                       i_in_first,
  input  logic [OF_BW-1:0]           i_in_data,
  output logic                       o_ot_valid,
  output logic [FC_IN_VEC*OF_BW-1:0] o_ot_fmap,
  output logic                       o_busy,
  output logic                       o_sync_err,
  output logic [7:0]                 o_frame_cnt
);

  localparam int            CW       = (FC_IN_VEC > 1) ? $clog2(FC_IN_VEC) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FC_IN_VEC - 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    valid_q;
  logic [7:0]              frame_cnt_q;
  logic [FC_IN_VEC*OF_BW-1:0] fmap_q;

  logic                    wr_en;
  logic [CW-1:0]           wr_idx;
  logic [OF_BW-1:0]        buf_q [FC_IN_VEC];
  logic [FC_IN_VEC*OF_BW-1:0] coll_flat;

  // Next-state logic: pick the buffer slot, advance the index, flag framing errors.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    if (i_in_valid) begin
      if (state_q == S_IDLE && !i_in_first) begin
        // Orphan element with no vector open: discard it.
        err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (i_in_first) begin
          wr_idx = '0;
          // A first marker inside an open vector drops the partial one.
          err_d  = (state_q == S_FILL);
        end
        if (wr_idx == LAST_IDX) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = wr_idx + CW'(1);
          state_d = S_FILL;
        end
      end
    end
  end

  // Control and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      fmap_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= done_q;
      if (done_q) begin
        fmap_q      <= coll_flat;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  // Collect buffer: holds the vector being assembled.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately not reset; stale contents never reach the output because only a full fill sets done_q.
    if (wr_en) begin
      buf_q[wr_idx] <= i_in_data;
    end
  end

  // Flatten the buffer so element k sits at bits [k*OF_BW +: OF_BW].
  always_comb begin
    coll_flat = '0;
    for (int k = 0; k < FC_IN_VEC; k++) begin
      coll_flat[k*OF_BW +: OF_BW] = buf_q[k];
    end
  end

  assign o_ot_valid  = valid_q;
  assign o_ot_fmap   = fmap_q;
  assign o_busy      = (state_q == S_FILL);
  assign o_sync_err  = err_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule
